sid_dac_serializer: RTL and testbench

//  Dual-channel serial link from SID voice-mix outputs to two DAC7611 12-bit DACs.

---
 rtl/sid_dac_serializer.sv | 144 ++++++++++++++
 tb/tb_sid_dac_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_dac_serializer.sv
// Dual-channel serializer feeding two DAC7611 12-bit DACs from SID mixer samples.
// Both channels share dac_clk/dac_le; a one-deep pending slot holds a pair strobed mid-frame.
`timescale 1ns/1ps

module sid_dac_serializer #(
  parameter int CLK_DIV   = 2,
  parameter int LE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [11:0] sample_1,
  input  logic [11:0] sample_2,
  input  logic        sample_valid,
  output logic        dac_clk,
  output logic        dac_dat_1,
  output logic        dac_dat_2,
  output logic        dac_le,
  output logic        busy,
  output logic        overrun
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(LE_CYCLES + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV);
  localparam logic [LW-1:0] LE_LAST = LW'(LE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t          r_state;
  logic [11:0]     r_sh1;
  logic [11:0]     r_sh2;
  logic [11:0]     r_pend1;
  logic [11:0]     r_pend2;
  logic            r_pendValid;
  logic [3:0]      r_bitCnt;
  logic [DW-1:0]   r_divCnt;
  logic [LW-1:0]   r_leCnt;
  logic            r_dacClk;
  logic            r_dat1;
  logic            r_dat2;
  logic            r_dacLe;
  logic            r_busy;
  logic            r_overrun;

  // A zero divider count marks the first SHIFT cycle, where bit 11 is presented
  // one full half-period ahead of the first rising edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_pend1     <= '0;
      r_pend2     <= '0;
      r_pendValid <= 1'b0;
      r_bitCnt    <= '0;
      r_divCnt    <= '0;
      r_leCnt     <= '0;
      r_dacClk    <= 1'b0;
      r_dat1      <= 1'b0;
      r_dat2      <= 1'b0;
      r_dacLe     <= 1'b1;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_sh1       <= sample_1;
            r_sh2       <= sample_2;
            r_pendValid <= 1'b0;
            r_overrun   <= r_pendValid;
            r_bitCnt    <= 4'd11;
            r_divCnt    <= '0;
            r_state     <= SHIFT;
          end else if (r_pendValid) begin
            r_sh1       <= r_pend1;
            r_sh2       <= r_pend2;
            r_pendValid <= 1'b0;
            r_bitCnt    <= 4'd11;
            r_divCnt    <= '0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_divCnt == '0) begin
            r_busy   <= 1'b1;
            r_dat1   <= r_sh1[11];
            r_dat2   <= r_sh2[11];
            r_divCnt <= DW'(1);
          end else if (r_divCnt == DIV_MAX) begin
            r_divCnt <= DW'(1);
            if (!r_dacClk) begin
              r_dacClk <= 1'b1;
            end else begin
              r_dacClk <= 1'b0;
              if (r_bitCnt == 4'd0) begin
                r_dacLe <= 1'b0;
                r_dat1  <= 1'b0;
                r_dat2  <= 1'b0;
                r_leCnt <= '0;
                r_state <= LATCH;
              end else begin
                r_bitCnt <= r_bitCnt - 4'd1;
                r_sh1    <= r_sh1 << 1;
                r_sh2    <= r_sh2 << 1;
                r_dat1   <= r_sh1[10];
                r_dat2   <= r_sh2[10];
              end
            end
          end else begin
            r_divCnt <= r_divCnt + DW'(1);
          end
        end
        LATCH: begin
          if (r_leCnt == LE_LAST) begin
            r_dacLe <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_leCnt <= r_leCnt + LW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      // Strobes during a frame park in the pending slot; the newest pair always wins.
      if (sample_valid && (r_state != IDLE)) begin
        r_pend1     <= sample_1;
        r_pend2     <= sample_2;
        r_pendValid <= 1'b1;
        r_overrun   <= r_pendValid;
      end
    end
  end

  assign dac_clk   = r_dacClk;
  assign dac_dat_1 = r_dat1;
  assign dac_dat_2 = r_dat2;
  assign dac_le    = r_dacLe;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sid_dac_serializer.sv
// Directed bench for sid_dac_serializer: DAC shift/latch models on two instances
// (default timing and CLK_DIV=1/LE_CYCLES=1), immediate assertions at each check point.
`timescale 1ns/1ps

module tb_sid_dac_serializer;

  logic clk = 1'b0;
  logic rstB = 1'b0;

  logic [11:0] s1A = '0, s2A = '0;
  logic        validA = 1'b0;
  logic        dacClkA, dat1A, dat2A, leA, busyA, ovA;

  logic [11:0] s1B = '0, s2B = '0;
  logic        validB = 1'b0;
  logic        dacClkB, dat1B, dat2B, leB, busyB, ovB;

  int assertCount = 0;
  int failCount   = 0;

  logic [11:0] shA1 = '0, shA2 = '0, latA1 = '0, latA2 = '0;
  logic [11:0] shB1 = '0, shB2 = '0, latB1 = '0, latB2 = '0;
  int          latCntA = 0, latCntB = 0;

  always #5 clk = ~clk;

  sid_dac_serializer #(.CLK_DIV(2), .LE_CYCLES(2)) dutA (
    .clk(clk), .rst_b(rstB), .sample_1(s1A), .sample_2(s2A), .sample_valid(validA),
    .dac_clk(dacClkA), .dac_dat_1(dat1A), .dac_dat_2(dat2A), .dac_le(leA),
    .busy(busyA), .overrun(ovA)
  );

  sid_dac_serializer #(.CLK_DIV(1), .LE_CYCLES(1)) dutB (
    .clk(clk), .rst_b(rstB), .sample_1(s1B), .sample_2(s2B), .sample_valid(validB),
    .dac_clk(dacClkB), .dac_dat_1(dat1B), .dac_dat_2(dat2B), .dac_le(leB),
    .busy(busyB), .overrun(ovB)
  );

  // DAC7611 behaviour: shift on dac_clk rise, latch last 12 bits on dac_le rise.
  always @(posedge dacClkA) begin
    shA1 <= {shA1[10:0], dat1A};
    shA2 <= {shA2[10:0], dat2A};
  end
  always @(posedge leA) begin
    if (rstB) begin
      latA1   <= shA1;
      latA2   <= shA2;
      latCntA <= latCntA + 1;
    end
  end
  always @(posedge dacClkB) begin
    shB1 <= {shB1[10:0], dat1B};
    shB2 <= {shB2[10:0], dat2B};
  end
  always @(posedge leB) begin
    if (rstB) begin
      latB1   <= shB1;
      latB2   <= shB2;
      latCntB <= latCntB + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulusA(input logic [11:0] a, input logic [11:0] b);
    s1A = a;
    s2A = b;
    validA = 1'b1;
  endtask

  task automatic applyStimulusB(input logic [11:0] a, input logic [11:0] b);
    s1B = a;
    s2B = b;
    validB = 1'b1;
  endtask

  initial begin
    int busyCnt, riseCnt, leLowCnt, ovCnt, base;
    int lastChange, lastRise;
    logic prevClk, holdPending;
    logic [1:0] prevDat;
    logic [11:0] val;

    // Reset values
    step();
    step();
    checkOutput("rst_dac_clk", dacClkA, 1'b0);
    checkOutput("rst_dat_1", dat1A, 1'b0);
    checkOutput("rst_dat_2", dat2A, 1'b0);
    checkOutput("rst_dac_le", leA, 1'b1);
    checkOutput("rst_busy", busyA, 1'b0);
    checkOutput("rst_overrun", ovA, 1'b0);
    checkOutput("rst_B_dac_le", leB, 1'b1);
    rstB = 1'b1;
    step();
    step();

    // Single frame 0x800/0x25A with bit timing checks
    $display("[TB] single frame");
    applyStimulusA(12'h800, 12'h25A);
    step();
    validA = 1'b0;
    s1A = 12'hFFF;
    s2A = 12'hFFF;
    busyCnt = 0; riseCnt = 0; leLowCnt = 0;
    prevClk = dacClkA; prevDat = {dat1A, dat2A};
    lastChange = 0; lastRise = 0; holdPending = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      step();
      if (busyA) busyCnt++;
      if (!leA) leLowCnt++;
      if (dacClkA && !prevClk) begin
        riseCnt++;
        checkOutput("setup", (i - lastChange) >= 2, 1'b1);
        lastRise = i;
        holdPending = 1'b1;
      end
      if (!dacClkA && prevClk) checkOutput("clk_high_len", i - lastRise, 2);
      if ({dat1A, dat2A} != prevDat) begin
        if (holdPending) checkOutput("hold", (i - lastRise) >= 2, 1'b1);
        holdPending = 1'b0;
        lastChange = i;
      end
      prevClk = dacClkA;
      prevDat = {dat1A, dat2A};
      if (i == 1) begin
        checkOutput("bit11_ch1", dat1A, 1'b1);
        checkOutput("bit11_ch2", dat2A, 1'b0);
        checkOutput("first_clk_low", dacClkA, 1'b0);
      end
      if (i == 3) checkOutput("first_rise", dacClkA, 1'b1);
      if (i == 49) checkOutput("le_fall", leA, 1'b0);
      if (i == 51) begin
        checkOutput("le_rise", leA, 1'b1);
        checkOutput("busy_drop", busyA, 1'b0);
        checkOutput("latch1_ch1", latA1, 12'h800);
        checkOutput("latch1_ch2", latA2, 12'h25A);
        checkOutput("latch1_cnt", latCntA, 1);
      end
    end
    checkOutput("busy_cycles", busyCnt, 50);
    checkOutput("rise_count", riseCnt, 12);
    checkOutput("le_low_cycles", leLowCnt, 2);

    // Strobe during frame goes to pending, no overrun
    $display("[TB] pending pair");
    base = latCntA;
    ovCnt = 0;
    applyStimulusA(12'h111, 12'h222);
    step();
    for (int i = 1; i <= 110; i++) begin
      validA = 1'b0;
      if (i == 10) applyStimulusA(12'h333, 12'h444);
      step();
      if (ovA) ovCnt++;
      if (i == 51) begin
        checkOutput("p_latch1_ch1", latA1, 12'h111);
        checkOutput("p_latch1_ch2", latA2, 12'h222);
        checkOutput("p_latch1_cnt", latCntA, base + 1);
      end
      if (i == 52) checkOutput("p_idle_gap", busyA, 1'b0);
      if (i == 53) checkOutput("p_busy2", busyA, 1'b1);
      if (i == 54) checkOutput("p_clk2_low", dacClkA, 1'b0);
      if (i == 55) checkOutput("p_clk2_rise", dacClkA, 1'b1);
      if (i == 103) begin
        checkOutput("p_latch2_ch1", latA1, 12'h333);
        checkOutput("p_latch2_ch2", latA2, 12'h444);
        checkOutput("p_latch2_cnt", latCntA, base + 2);
      end
    end
    validA = 1'b0;
    checkOutput("p_no_overrun", ovCnt, 0);

    // Three strobes: middle pair discarded with one overrun
    $display("[TB] overrun");
    base = latCntA;
    ovCnt = 0;
    applyStimulusA(12'hAAA, 12'h555);
    step();
    for (int i = 1; i <= 110; i++) begin
      validA = 1'b0;
      if (i == 5) applyStimulusA(12'hBBB, 12'h444);
      if (i == 9) applyStimulusA(12'hCCC, 12'h333);
      step();
      if (ovA) ovCnt++;
      if (i == 9) checkOutput("o_pulse", ovA, 1'b1);
      if (i == 51) checkOutput("o_latch1_ch1", latA1, 12'hAAA);
      if (i == 103) begin
        checkOutput("o_latch2_ch1", latA1, 12'hCCC);
        checkOutput("o_latch2_ch2", latA2, 12'h333);
        checkOutput("o_latch_cnt", latCntA, base + 2);
      end
    end
    validA = 1'b0;
    checkOutput("o_pulse_count", ovCnt, 1);

    // Async reset at bit 6 aborts the frame without latching
    $display("[TB] mid-frame reset");
    base = latCntA;
    applyStimulusA(12'h5A5, 12'h0F0);
    step();
    validA = 1'b0;
    for (int i = 1; i <= 23; i++) step();
    checkOutput("r_clk_high_pre", dacClkA, 1'b1);
    rstB = 1'b0;
    #1;
    checkOutput("r_dac_clk", dacClkA, 1'b0);
    checkOutput("r_dat_1", dat1A, 1'b0);
    checkOutput("r_dat_2", dat2A, 1'b0);
    checkOutput("r_dac_le", leA, 1'b1);
    checkOutput("r_busy", busyA, 1'b0);
    checkOutput("r_latch_cnt", latCntA, base);
    checkOutput("r_latch_hold", latA1, 12'hCCC);
    #3;
    rstB = 1'b1;
    step();
    step();
    applyStimulusA(12'h123, 12'h456);
    step();
    validA = 1'b0;
    for (int i = 1; i <= 55; i++) step();
    checkOutput("r_post_ch1", latA1, 12'h123);
    checkOutput("r_post_ch2", latA2, 12'h456);
    checkOutput("r_post_cnt", latCntA, base + 1);

    // CLK_DIV=1, LE_CYCLES=1 ramp
    $display("[TB] fast ramp");
    for (int v = 0; v < 16; v++) begin
      val = 12'(v * 12'h111);
      base = latCntB;
      applyStimulusB(val, 12'hFFF - val);
      step();
      validB = 1'b0;
      busyCnt = 0;
      for (int i = 1; i <= 27; i++) begin
        step();
        if (busyB) busyCnt++;
        if (i == 26) checkOutput("f_latch_time", latCntB, base + 1);
      end
      checkOutput("f_busy_cycles", busyCnt, 25);
      checkOutput("f_ch1", latB1, val);
      checkOutput("f_ch2", latB2, 12'hFFF - val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
